// File: rtl/req_ack_pkg.sv
// req_ack_pkg: shared types and elaboration-time helpers for req_ack_responder.
//   gap_state_t  - per-channel minimum-gap FSM state
//   params_ok    - legality check of the responder parameters
//   gap_cnt_w    - width of the hold-off counter for a given MIN_GAP
package req_ack_pkg;

    typedef enum logic {
        GAP_IDLE    = 1'b0,
        GAP_HOLDOFF = 1'b1
    } gap_state_t;

    function automatic bit params_ok(int num_ch, int ack_latency, int min_gap, int cnt_w);
        return (num_ch >= 1) && (ack_latency >= 1) && (min_gap >= 1) && (cnt_w >= 2);
    endfunction

    // Counter only has to hold MIN_GAP-1; keep at least one bit so MIN_GAP=1 still elaborates.
    function automatic int gap_cnt_w(int min_gap);
        return (min_gap > 1) ? $clog2(min_gap) : 1;
    endfunction

endpackage

// File: rtl/req_ack_channel.sv
// req_ack_channel: one responder channel.
//   clk, rst_n (sync, active low), req (pulse in), err_clr (clear gap_err)
//   ack (registered pulse ACK_LATENCY cycles after an accepted req)
//   busy (any ack in flight), gap_err (sticky drop flag)
//   reqs_seen / acks_seen (saturating CNT_W-bit counters)
// Optional checks: define REQ_ACK_RESPONDER_ASSERT_EN.
module req_ack_channel
    import req_ack_pkg::*;
#(
    parameter int ACK_LATENCY = 4,
    parameter int MIN_GAP     = 8,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req,
    input  logic             err_clr,
    output logic             ack,
    output logic             busy,
    output logic             gap_err,
    output logic [CNT_W-1:0] reqs_seen,
    output logic [CNT_W-1:0] acks_seen
);

    localparam int               GW       = gap_cnt_w(MIN_GAP);
    localparam logic [GW-1:0]    GAP_LOAD = GW'(MIN_GAP - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    gap_state_t             state, state_nxt;
    logic [GW-1:0]          gap_cnt, gap_cnt_nxt;
    logic                   accept, drop;
    logic [ACK_LATENCY-1:0] dly;

    // Gap FSM: state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= GAP_IDLE;
            gap_cnt <= '0;
        end else begin
            state   <= state_nxt;
            gap_cnt <= gap_cnt_nxt;
        end
    end

    // Gap FSM: next state. Leaving HOLDOFF on count 1 makes cycle n+MIN_GAP
    // the first one judged in IDLE again.
    always_comb begin
        state_nxt   = state;
        gap_cnt_nxt = gap_cnt;
        case (state)
            GAP_IDLE: begin
                if (req && (MIN_GAP > 1)) begin
                    state_nxt   = GAP_HOLDOFF;
                    gap_cnt_nxt = GAP_LOAD;
                end
            end
            GAP_HOLDOFF: begin
                if (gap_cnt <= 1) begin
                    state_nxt   = GAP_IDLE;
                    gap_cnt_nxt = '0;
                end else begin
                    gap_cnt_nxt = gap_cnt - 1'b1;
                end
            end
            default: begin
                state_nxt   = GAP_IDLE;
                gap_cnt_nxt = '0;
            end
        endcase
    end

    // Gap FSM: outputs
    always_comb begin
        accept = (state == GAP_IDLE) && req;
        drop   = (state == GAP_HOLDOFF) && req;
    end

    // Delay line; the last stage is the registered ack.
    generate
        if (ACK_LATENCY == 1) begin : g_dly1
            always_ff @(posedge clk) begin
                if (!rst_n) dly <= '0;
                else        dly <= accept;
            end
        end else begin : g_dlyn
            always_ff @(posedge clk) begin
                if (!rst_n) dly <= '0;
                else        dly <= {dly[ACK_LATENCY-2:0], accept};
            end
        end
    endgenerate

    assign ack  = dly[ACK_LATENCY-1];
    assign busy = |dly;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            reqs_seen <= '0;
            acks_seen <= '0;
            gap_err   <= 1'b0;
        end else begin
            if (accept && (reqs_seen != CNT_MAX)) reqs_seen <= reqs_seen + 1'b1;
            if (ack && (acks_seen != CNT_MAX))    acks_seen <= acks_seen + 1'b1;
            // a drop in the same cycle as err_clr keeps the flag set
            if (drop)         gap_err <= 1'b1;
            else if (err_clr) gap_err <= 1'b0;
        end
    end

`ifdef REQ_ACK_RESPONDER_ASSERT_EN
    logic gap_err_q, drop_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gap_err_q <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            gap_err_q <= gap_err;
            drop_q    <= drop;
        end
    end

    always @(posedge clk) begin
        if (rst_n) begin
            a_state: assert (state == GAP_IDLE || state == GAP_HOLDOFF)
                else $error("req_ack_channel: illegal gap state");
            a_cnt: assert (reqs_seen == CNT_MAX || acks_seen <= reqs_seen)
                else $error("req_ack_channel: acks_seen exceeds reqs_seen");
            a_ack: assert (!ack || dly[ACK_LATENCY-1])
                else $error("req_ack_channel: ack without delay-line tap");
            a_gap: assert (!(gap_err && !gap_err_q) || drop_q)
                else $error("req_ack_channel: gap_err rose without a drop");
        end
    end

    c_accept:   cover property (@(posedge clk) rst_n && accept);
    c_drop:     cover property (@(posedge clk) rst_n && drop);
    c_ack_acc:  cover property (@(posedge clk) rst_n && ack && accept);
`endif

endmodule

// File: rtl/req_ack_responder.sv
// req_ack_responder: NUM_CH independent req/ack responder channels.
//   clk, rst_n (sync, active low), req[NUM_CH], err_clr (clears all gap_err)
//   ack/busy/gap_err[NUM_CH]; reqs_seen/acks_seen packed, channel c at [c*CNT_W +: CNT_W]
// Optional checks: define REQ_ACK_RESPONDER_ASSERT_EN (passed through to each channel).
module req_ack_responder
    import req_ack_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int ACK_LATENCY = 4,
    parameter int MIN_GAP     = 8,
    parameter int CNT_W       = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       req,
    input  logic                    err_clr,
    output logic [NUM_CH-1:0]       ack,
    output logic [NUM_CH-1:0]       busy,
    output logic [NUM_CH-1:0]       gap_err,
    output logic [NUM_CH*CNT_W-1:0] reqs_seen,
    output logic [NUM_CH*CNT_W-1:0] acks_seen
);

    generate
        if (!params_ok(NUM_CH, ACK_LATENCY, MIN_GAP, CNT_W)) begin : g_param_err
            $error("req_ack_responder: illegal parameter set");
        end

        for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
            req_ack_channel #(
                .ACK_LATENCY (ACK_LATENCY),
                .MIN_GAP     (MIN_GAP),
                .CNT_W       (CNT_W)
            ) u_ch (
                .clk       (clk),
                .rst_n     (rst_n),
                .req       (req[c]),
                .err_clr   (err_clr),
                .ack       (ack[c]),
                .busy      (busy[c]),
                .gap_err   (gap_err[c]),
                .reqs_seen (reqs_seen[c*CNT_W +: CNT_W]),
                .acks_seen (acks_seen[c*CNT_W +: CNT_W])
            );
        end
    endgenerate

endmodule

// File: tb/tb_req_ack_responder.sv
module tb_req_ack_responder;

    localparam int NI = 3;
    localparam int NCH [NI] = '{2, 2, 1};
    localparam int LAT [NI] = '{4, 4, 3};
    localparam int GAP [NI] = '{8, 1, 2};
    localparam int CW  [NI] = '{8, 8, 2};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, err_clr;
    logic [1:0]  req0, req1;
    logic [0:0]  req2;
    logic [1:0]  ack0, busy0, gerr0, ack1, busy1, gerr1;
    logic [0:0]  ack2, busy2, gerr2;
    logic [15:0] rs0, as0, rs1, as1;
    logic [1:0]  rs2, as2;

    req_ack_responder #(.NUM_CH(2), .ACK_LATENCY(4), .MIN_GAP(8), .CNT_W(8)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .req(req0), .err_clr(err_clr), .ack(ack0), .busy(busy0),
        .gap_err(gerr0), .reqs_seen(rs0), .acks_seen(as0));
    req_ack_responder #(.NUM_CH(2), .ACK_LATENCY(4), .MIN_GAP(1), .CNT_W(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req(req1), .err_clr(err_clr), .ack(ack1), .busy(busy1),
        .gap_err(gerr1), .reqs_seen(rs1), .acks_seen(as1));
    req_ack_responder #(.NUM_CH(1), .ACK_LATENCY(3), .MIN_GAP(2), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .req(req2), .err_clr(err_clr), .ack(ack2), .busy(busy2),
        .gap_err(gerr2), .reqs_seen(rs2), .acks_seen(as2));

    int n_assert = 0;
    int n_fail   = 0;
    int t        = 0;

    // Reference model: a channel remembers when it last accepted and which
    // accept times still owe an ack (ack due at accept time + latency).
    bit has_acc  [NI][2];
    int last_acc [NI][2];
    int acc_q    [NI][2][$];
    int rcnt     [NI][2];
    int acnt     [NI][2];
    bit gerr     [NI][2];

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit get_req(int i, int c);
        case (i)
            0:       return req0[c];
            1:       return req1[c];
            default: return req2[0];
        endcase
    endfunction

    function automatic string kname(int k);
        case (k)
            0:       return "ack";
            1:       return "busy";
            2:       return "gap_err";
            3:       return "reqs_seen";
            default: return "acks_seen";
        endcase
    endfunction

    function automatic logic [31:0] d_val(int i, int c, int k);
        case (i)
            0: case (k)
                0:       return 32'(ack0[c]);
                1:       return 32'(busy0[c]);
                2:       return 32'(gerr0[c]);
                3:       return 32'(rs0[c*8 +: 8]);
                default: return 32'(as0[c*8 +: 8]);
            endcase
            1: case (k)
                0:       return 32'(ack1[c]);
                1:       return 32'(busy1[c]);
                2:       return 32'(gerr1[c]);
                3:       return 32'(rs1[c*8 +: 8]);
                default: return 32'(as1[c*8 +: 8]);
            endcase
            default: case (k)
                0:       return 32'(ack2[0]);
                1:       return 32'(busy2[0]);
                2:       return 32'(gerr2[0]);
                3:       return 32'(rs2);
                default: return 32'(as2);
            endcase
        endcase
    endfunction

    function automatic logic [31:0] e_val(int i, int c, int k);
        case (k)
            0:       return 32'(acc_q[i][c].size() > 0 && acc_q[i][c][0] + LAT[i] == t);
            1:       return 32'(acc_q[i][c].size() > 0);
            2:       return 32'(gerr[i][c]);
            3:       return 32'(rcnt[i][c]);
            default: return 32'(acnt[i][c]);
        endcase
    endfunction

    task automatic model_edge();
        bit r, drop;
        int mx;
        for (int i = 0; i < NI; i++) begin
            mx = (1 << CW[i]) - 1;
            for (int c = 0; c < NCH[i]; c++) begin
                if (!rst_n) begin
                    has_acc[i][c] = 0; rcnt[i][c] = 0; acnt[i][c] = 0; gerr[i][c] = 0;
                    acc_q[i][c].delete();
                end else begin
                    r    = get_req(i, c);
                    drop = r && has_acc[i][c] && (t - last_acc[i][c] < GAP[i]);
                    if (acc_q[i][c].size() > 0 && acc_q[i][c][0] + LAT[i] == t) begin
                        void'(acc_q[i][c].pop_front());
                        if (acnt[i][c] < mx) acnt[i][c]++;
                    end
                    if (drop)         gerr[i][c] = 1;
                    else if (err_clr) gerr[i][c] = 0;
                    if (r && !drop) begin
                        if (rcnt[i][c] < mx) rcnt[i][c]++;
                        has_acc[i][c]  = 1;
                        last_acc[i][c] = t;
                        acc_q[i][c].push_back(t);
                    end
                end
            end
        end
    endtask

    task automatic model_check();
        for (int i = 0; i < NI; i++)
            for (int c = 0; c < NCH[i]; c++)
                for (int k = 0; k < 5; k++)
                    chk($sformatf("model %s i%0d c%0d t%0d", kname(k), i, c, t),
                        d_val(i, c, k), e_val(i, c, k));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        t++;
        #1;
        model_check();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req0 = '0; req1 = '0; req2 = '0; err_clr = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    int b, k, n_ack2;

    initial begin
        rst_n = 1'b0; req0 = '0; req1 = '0; req2 = '0; err_clr = 1'b0;
        #1;

        // Directed run: all three instances share the cycle frame
        do_reset();
        chk("reset rs0", 32'(rs0), 0);
        chk("reset busy0", 32'(busy0), 0);
        b = t; n_ack2 = 0;
        for (k = 0; k <= 30; k++) begin
            chk($sformatf("A ack0[0] k%0d", k),  32'(ack0[0]), 32'(k == 14));
            chk($sformatf("A busy0[0] k%0d", k), 32'(busy0[0]), 32'(k >= 11 && k <= 14));
            chk($sformatf("A rs0[0] k%0d", k),   32'(rs0[7:0]), 32'(k >= 11));
            chk($sformatf("A as0[0] k%0d", k),   32'(as0[7:0]), 32'(k >= 15));
            chk($sformatf("A gerr0[1] k%0d", k), 32'(gerr0[1]), 32'(k >= 16));
            chk($sformatf("A ack0[1] k%0d", k),  32'(ack0[1]), 32'(k == 14 || k == 22));
            chk($sformatf("A ack1[0] k%0d", k),  32'(ack1[0]), 32'(k >= 9 && k <= 11));
            if (ack2[0]) n_ack2++;
            req0 = {1'(k == 10 || k == 15 || k == 18), 1'(k == 10)};
            req1 = {1'b0, 1'(k >= 5 && k <= 7)};
            req2 = 1'(k == 2 || k == 6 || k == 10 || k == 14 || k == 18);
            tick();
        end
        chk("A inst2 ack count", 32'(n_ack2), 5);
        chk("A inst2 rs sat", 32'(rs2), 3);
        chk("A inst2 as sat", 32'(as2), 3);
        chk("A inst1 rs", 32'(rs1[7:0]), 3);
        chk("A inst1 as", 32'(as1[7:0]), 3);

        // Reset while an ack is in flight
        do_reset();
        b = t;
        for (k = 0; k <= 16; k++) begin
            if (k == 11) chk("B busy before reset", 32'(busy0[0]), 1);
            if (k >= 13) chk($sformatf("B ack0 k%0d", k), 32'(ack0[0]), 0);
            if (k == 13) begin
                chk("B busy after reset", 32'(busy0), 0);
                chk("B rs after reset", 32'(rs0), 0);
                chk("B as after reset", 32'(as0), 0);
                chk("B gerr after reset", 32'(gerr0), 0);
            end
            req0  = {1'b0, 1'(k == 10)};
            rst_n = (k != 12);
            tick();
        end
        rst_n = 1'b1;

        // err_clr against a simultaneous violation, then alone
        do_reset();
        for (k = 0; k <= 7; k++) begin
            chk($sformatf("C gerr0[1] k%0d", k), 32'(gerr0[1]), 32'(k == 3 || k == 4));
            req0    = {1'(k >= 1 && k <= 3), 1'b0};
            err_clr = (k == 3 || k == 4);
            tick();
        end

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            req0    = {1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 5) == 0)};
            req1    = {1'($urandom_range(0, 1) == 0), 1'($urandom_range(0, 3) == 0)};
            req2    = 1'($urandom_range(0, 2) == 0);
            err_clr = ($urandom_range(0, 15) == 0);
            rst_n   = ($urandom_range(0, 299) != 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/req_ack_responder.md
# req_ack_responder

Multi-channel, parametrised request/acknowledge responder: each channel accepts single-cycle request pulses and returns a single-cycle acknowledge a fixed number of cycles later. Requests arriving inside the per-channel minimum-gap window are dropped and flagged. Per-channel saturating counters track accepted requests and issued acks. The block sits as the responder side of req/ack handshakes in the staged simulation and verification flow, replacing the fixed 1-channel, latency-4, gap-8 behaviour with a configurable one.

## Interface
- NUM_CH, 2: number of independent channels (>=1)
- ACK_LATENCY, 4: cycles from accepted req to ack (>=1)
- MIN_GAP, 8: minimum cycles between accepted reqs on one channel (>=1; 1 = no restriction)
- CNT_W, 8: width of each per-channel counter (>=2)

- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- req  in  NUM_CH  per-channel request pulse
- err_clr  in  1  clears all gap_err bits
- ack  out  NUM_CH  per-channel acknowledge pulse, registered
- busy  out  NUM_CH  channel has at least one ack in flight
- gap_err  out  NUM_CH  sticky: a req was dropped for violating MIN_GAP
- reqs_seen  out  NUM_CH*CNT_W  accepted-request count, channel c at [c*CNT_W +: CNT_W]
- acks_seen  out  NUM_CH*CNT_W  issued-ack count, same packing

## Operation
- Channels fully independent; no arbitration, no shared state except err_clr.
- Per-channel gap FSM, states IDLE and HOLDOFF:
  - IDLE: req=1 → accept; if MIN_GAP>1 go HOLDOFF with gap counter = MIN_GAP-1.
  - HOLDOFF: counter decrements each cycle; req=1 here → dropped, gap_err set; at counter reaching 0 return IDLE (req in that same cycle is judged in IDLE next cycle, i.e. first accept cycle is n+MIN_GAP).
  - MIN_GAP=1: FSM stays in IDLE; every req cycle accepted, including req held high.
- Accepted req enters an ACK_LATENCY-deep per-channel delay line; ack is the last stage. Multiple reqs may be in flight when MIN_GAP < ACK_LATENCY.
- busy = OR of all delay-line stages.
- reqs_seen increments on each accepted req; acks_seen on each ack cycle; both saturate at 2^CNT_W-1, never wrap.
- gap_err: set on any dropped req; cleared by err_clr; set wins if both occur in the same cycle.

## Timing
- Reset (rst_n=0 at an edge): ack=0, busy=0, gap_err=0, both counters 0, FSM IDLE, delay line cleared. Reset mid-operation discards in-flight acks; no ack is emitted for reqs accepted before reset.
- req high in cycle n and accepted → ack high exactly in cycle n+ACK_LATENCY for one cycle; reqs_seen updated in cycle n+1; acks_seen in cycle n+ACK_LATENCY+1.
- Accepted req in cycle n: reqs in n+1 .. n+MIN_GAP-1 dropped; gap_err visible from the cycle after the dropped req.
- Dropped reqs produce no ack and no count change.
- err_clr takes effect in the following cycle.
- Counter at saturation: further events leave it unchanged; ack still emitted.

## Configuration
- REQ_ACK_RESPONDER_ASSERT_EN defined: embedded immediate assertions compiled in, checked every cycle out of reset: acks_seen <= reqs_seen per channel (until saturation), ack[c] only when delay-line tap set, gap_err rises only on a dropped req, FSM never in illegal state. Cover statements for an accepted req, a dropped req, and ack in the same cycle as a new accepted req.
- Undefined: no assertions or covers; ports and functional behaviour identical.

## Structure
- Package req_ack_pkg: gap FSM state enum (GAP_IDLE, GAP_HOLDOFF), parameter legality checks as constant functions.
- Sub-module req_ack_channel: one channel (gap FSM, delay line, two counters, gap_err); top instantiates NUM_CH copies via generate and packs outputs.

## Test plan
- Defaults, req[0] pulse in cycle 10 → ack[0] high in cycle 14 only; reqs_seen[0]=1 from cycle 11, acks_seen[0]=1 from 15; busy[0] high cycles 11–14.
- Defaults, req[1] in cycles 10 and 15 → second dropped, gap_err[1]=1 from 16, one ack at 14; req at 18 accepted, ack at 22.
- MIN_GAP=1, ACK_LATENCY=4, req[0] held high cycles 5–7 → acks in 9, 10, 11; both counters end at 3.
- CNT_W=2, 5 spaced reqs on channel 0 → reqs_seen and acks_seen stick at 3; 5 acks observed.
- Req in cycle 10, rst_n=0 in cycle 12 → no ack in cycle 14; all outputs 0 after reset.
- gap_err set, err_clr and a new violation in same cycle → gap_err stays 1; err_clr alone next → 0.
